// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: frames bytes onto a UART tx line using ticks derived from baud_clk_16
module uart_tx_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int OVERSAMPLE = 16,
  parameter logic [15:0] BRD_RESET = 16'd325
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_clk_16,
  output logic [15:0]          brd,
  input  logic                 cfg_we,
  input  logic [15:0]          cfg_brd,
  input  logic                 cfg_par_en,
  input  logic                 cfg_par_odd,
  input  logic                 cfg_stop2,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  logic [2:0] state, nxt;
  logic s1, s2, s3, tick, bit_end, xfer, idle;
  logic [3:0] cnt;
  logic [2:0] idx;
  logic [DATA_BITS-1:0] shift, nxt_shift;
  logic par, par_en, par_odd, stop2;
  logic pend, pend_par_en, pend_par_odd, pend_stop2;
  logic [15:0] pend_brd;
  assign idle = state == IDLE;
  assign tick = s2 & ~s3;
  assign bit_end = tick && cnt == 4'(OVERSAMPLE - 1);
  assign tx_ready = idle && !pend;
  assign tx_busy = !idle;
  assign xfer = tx_valid && tx_ready;
  assign tx_done = state == STOP && bit_end && (!stop2 || idx[0]);
  // next-state and next-shift decode
  always_comb begin
    nxt = state == IDLE ? (xfer ? START : IDLE) :
          state == START ? (bit_end ? DATA : START) :
          state == DATA ? (bit_end && idx == 3'(DATA_BITS - 1) ? (par_en ? PARITY : STOP) : DATA) :
          state == PARITY ? (bit_end ? STOP : PARITY) :
          (tx_done ? IDLE : STOP);
    nxt_shift = state == DATA && bit_end ? shift >> 1 : shift;
  end
  // baud_clk_16 synchronizer and edge register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) {s1, s2, s3} <= 3'b000;
    else {s1, s2, s3} <= {baud_clk_16, s1, s2};
  end
  // frame sequencer: state, tick counter, bit index, shift register, registered tx
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      par <= 1'b0;
      tx <= 1'b1;
    end else begin
      state <= nxt;
      cnt <= xfer ? 4'd0 : tick && !idle ? cnt + 4'd1 : cnt;
      idx <= state != nxt ? 3'd0 : bit_end ? idx + 3'd1 : idx;
      shift <= xfer ? tx_data : nxt_shift;
      par <= xfer ? ^tx_data : par;
      tx <= nxt == IDLE || nxt == STOP ? 1'b1 : nxt == START ? 1'b0 : nxt == DATA ? nxt_shift[0] : par ^ par_odd;
    end
  end
  // config registers; writes during a frame wait in a shadow until the FSM is idle again
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      brd <= BRD_RESET;
      par_en <= 1'b0;
      par_odd <= 1'b0;
      stop2 <= 1'b0;
      pend <= 1'b0;
      pend_brd <= '0;
      pend_par_en <= 1'b0;
      pend_par_odd <= 1'b0;
      pend_stop2 <= 1'b0;
    end else if (cfg_we && idle) begin
      {brd, par_en, par_odd, stop2} <= {cfg_brd, cfg_par_en, cfg_par_odd, cfg_stop2};
      pend <= 1'b0;
    end else if (cfg_we) begin
      {pend_brd, pend_par_en, pend_par_odd, pend_stop2} <= {cfg_brd, cfg_par_en, cfg_par_odd, cfg_stop2};
      pend <= 1'b1;
    end else if (idle && pend) begin
      {brd, par_en, par_odd, stop2} <= {pend_brd, pend_par_en, pend_par_odd, pend_stop2};
      pend <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: randomized frames checked against a bit-list model of the UART frame
module tb_uart_tx_ctrl;
  logic clk = 1'b0, reset = 1'b0, baud = 1'b0;
  logic cfg_we = 1'b0, cfg_par_en = 1'b0, cfg_par_odd = 1'b0, cfg_stop2 = 1'b0;
  logic [15:0] cfg_brd = '0, brd;
  logic tx_valid = 1'b0, tx_ready, tx, tx_busy, tx_done;
  logic [7:0] tx_data = '0;
  int tests = 0, fails = 0, tick_no = 0, done_total = 0, done_at = 0;

  uart_tx_ctrl dut (
    .clk(clk), .reset(reset), .baud_clk_16(baud), .brd(brd),
    .cfg_we(cfg_we), .cfg_brd(cfg_brd), .cfg_par_en(cfg_par_en),
    .cfg_par_odd(cfg_par_odd), .cfg_stop2(cfg_stop2),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tx_done === 1'b1) begin
    done_total++;
    done_at = tick_no;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse();
    baud = 1'b1;
    tick_no++;
    repeat (3) @(negedge clk);
    baud = 1'b0;
    repeat ($urandom_range(3, 5)) @(negedge clk);
  endtask

  task automatic cfg_pulse(input logic [15:0] b);
    cfg_brd = b;
    cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic cfg_set(input logic [15:0] b, input logic pe, input logic po, input logic s2);
    cfg_par_en = pe;
    cfg_par_odd = po;
    cfg_stop2 = s2;
    cfg_pulse(b);
    @(negedge clk);
    chk("cfg_brd", brd, b);
    chk("cfg_ready", tx_ready, 1);
  endtask

  task automatic send(input logic [7:0] d, input logic hold, input logic [7:0] d2);
    int n = 0;
    tx_valid = 1'b1;
    tx_data = d;
    while (!tx_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", tx_ready, 1);
    @(posedge clk);
    #1;
    tx_valid = hold;
    tx_data = hold ? d2 : $urandom;
    @(negedge clk);
  endtask

  // mode 0: plain frame, 1: next byte queued, 2: brd rewritten mid-frame
  task automatic run_ticks(input logic [7:0] d, input logic pe, input logic po, input logic s2,
                           input int mode, input logic [15:0] b_old, input logic [15:0] b_new);
    logic [11:0] bits;
    int len, base;
    logic seen;
    len = 10 + int'(pe) + int'(s2);
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    if (pe) bits[9] = (($countones(d) % 2) == 1) ^ po;
    tick_no = 0;
    base = done_total;
    chk("start_tx", tx, 0);
    chk("start_busy", tx_busy, 1);
    for (int k = 1; k < len * 16; k++) begin
      pulse();
      if (k % 16 == 8) begin
        chk($sformatf("bit%0d_of_%02h", k / 16, d), tx, bits[k/16]);
        chk("mid_busy", tx_busy, 1);
      end
      if (mode == 2 && k == 40) cfg_pulse(b_new);
      if (mode == 2 && k == 56) chk("brd_hold", brd, b_old);
    end
    baud = 1'b1;
    tick_no++;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      seen = tx_done;
    end
    chk("done_seen", seen, 1);
    chk("done_busy", tx_busy, 1);
    @(negedge clk);
    chk("after_tx", tx, 1);
    chk("after_busy", tx_busy, 0);
    chk("after_ready", tx_ready, mode == 2 ? 0 : 1);
    if (mode == 2) chk("apply_brd_old", brd, b_old);
    @(negedge clk);
    if (mode == 1) begin
      chk("b2b_start_tx", tx, 0);
      chk("b2b_ready", tx_ready, 0);
      chk("b2b_busy", tx_busy, 1);
    end
    if (mode == 2) begin
      chk("apply_brd_new", brd, b_new);
      chk("apply_ready", tx_ready, 1);
    end
    baud = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_count", done_total - base, 1);
    chk("done_tick", done_at, len * 16);
  endtask

  initial begin
    logic [7:0] d;
    logic pe, po, s2;
    logic [15:0] b;
    repeat (3) @(negedge clk);
    chk("rst_brd", brd, 16'd325);
    chk("rst_tx", tx, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    reset = 1'b1;
    @(negedge clk);
    send(8'h55, 0, 0);
    run_ticks(8'h55, 0, 0, 0, 0, 0, 0);
    cfg_set(16'd325, 1, 0, 0);
    send(8'h07, 0, 0);
    run_ticks(8'h07, 1, 0, 0, 0, 0, 0);
    cfg_set(16'd325, 1, 1, 0);
    send(8'h07, 0, 0);
    run_ticks(8'h07, 1, 1, 0, 0, 0, 0);
    cfg_set(16'd325, 0, 0, 1);
    send(8'hFF, 0, 0);
    run_ticks(8'hFF, 0, 0, 1, 0, 0, 0);
    cfg_set(16'd325, 0, 0, 0);
    send(8'hA1, 1, 8'h3C);
    run_ticks(8'hA1, 0, 0, 0, 1, 0, 0);
    tx_valid = 1'b0;
    run_ticks(8'h3C, 0, 0, 0, 0, 0, 0);
    send(8'h5A, 0, 0);
    run_ticks(8'h5A, 0, 0, 0, 2, 16'd325, 16'h0010);
    send(8'h00, 0, 0);
    repeat (72) pulse();
    chk("abort_pre_tx", tx, 0);
    repeat (30) @(negedge clk);
    chk("stall_busy", tx_busy, 1);
    chk("stall_brd", brd, 16'h0010);
    reset = 1'b0;
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_busy", tx_busy, 0);
    chk("abort_ready", tx_ready, 1);
    chk("abort_brd", brd, 16'd325);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(8'hC3, 0, 0);
    run_ticks(8'hC3, 0, 0, 0, 0, 0, 0);
    for (int r = 0; r < 6; r++) begin
      d = 8'($urandom);
      pe = 1'($urandom);
      po = 1'($urandom);
      s2 = 1'($urandom);
      b = 16'($urandom_range(1, 65535));
      cfg_set(b, pe, po, s2);
      send(d, 0, 0);
      run_ticks(d, pe, po, s2, 0, 0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
